// File: rtl/pc_sequencer.sv
// Major-state controller for the PDP-8 instruction cycle: fetch, optional defer, then
// jump / jump-to-subroutine / execute with optional skip. Strobes are decoded from the state register.
module pc_sequencer #(
    parameter int ADDR_W     = 12,
    parameter bit AUTOIDX_EN = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RUN,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] PCLAT,
    input  logic [ADDR_W-1:0] MD,
    input  logic              MEM_ACK,
    input  logic              EXEC_DONE,
    input  logic              SKIP,
    output logic              PC_FETCH,
    output logic              PC_CK,
    output logic              PC_LD,
    output logic [ADDR_W-1:0] PC_IN,
    output logic              MEM_RD,
    output logic              MEM_WR,
    output logic [ADDR_W-1:0] MA,
    output logic [ADDR_W-1:0] WDATA,
    output logic [ADDR_W-1:0] IR,
    output logic [ADDR_W-1:0] EA,
    output logic              EXEC_GO,
    output logic [3:0]        STATE
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F0   = 4'd1,
        ST_F1   = 4'd2,
        ST_DEC  = 4'd3,
        ST_DEF  = 4'd4,
        ST_JWR  = 4'd5,
        ST_LDP  = 4'd6,
        ST_EXE  = 4'd7,
        ST_EXW  = 4'd8,
        ST_SKG  = 4'd9,
        ST_SKC  = 4'd10,
        ST_END  = 4'd11
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ir_reg, ir_next;
    logic [ADDR_W-1:0] ea_reg, ea_next;
    logic [ADDR_W-1:0] ea_direct;
    logic [2:0]        opcode;
    logic              wants_defer;

    // AUTOIDX_EN is a reserved parameter; elaboration stops if it is set.
    if (AUTOIDX_EN) begin : g_autoidx_reserved
        $error("pc_sequencer: AUTOIDX_EN is reserved and must be 0");
    end

    assign opcode      = ir_reg[11:9];
    assign wants_defer = (opcode < 3'd6) && ir_reg[8];

    // Offset bits come from the instruction; page bits from the fetch address when IR[7] selects current page.
    genvar gi;
    for (gi = 0; gi < ADDR_W; gi++) begin : g_ea_bit
        if (gi < 7) begin : g_offset
            assign ea_direct[gi] = ir_reg[gi];
        end else begin : g_page
            assign ea_direct[gi] = ir_reg[7] & PCLAT[gi];
        end
    end

    function automatic state_t dispatch(input logic [2:0] op);
        case (op)
            3'd5:    return ST_LDP;
            3'd4:    return ST_JWR;
            default: return ST_EXE;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            ir_reg    <= '0;
            ea_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
            ea_reg    <= ea_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ir_next    = ir_reg;
        ea_next    = ea_reg;
        PC_FETCH   = 1'b0;
        PC_CK      = 1'b0;
        PC_LD      = 1'b0;
        PC_IN      = '0;
        MEM_RD     = 1'b0;
        MEM_WR     = 1'b0;
        MA         = '0;
        WDATA      = '0;
        EXEC_GO    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (RUN) state_next = ST_F0;
            end
            ST_F0: begin
                PC_FETCH   = 1'b1;
                state_next = ST_F1;
            end
            ST_F1: begin
                MEM_RD = 1'b1;
                MA     = PCLAT;
                if (MEM_ACK) begin
                    ir_next    = MD;
                    state_next = ST_DEC;
                end
            end
            ST_DEC: begin
                ea_next = ea_direct;
                if (wants_defer) state_next = ST_DEF;
                else             state_next = dispatch(opcode);
            end
            ST_DEF: begin
                MEM_RD = 1'b1;
                MA     = ea_reg;
                if (MEM_ACK) begin
                    ea_next    = MD;
                    state_next = dispatch(opcode);
                end
            end
            ST_JWR: begin
                // PC already points past the JMS, so it is the return address.
                MEM_WR = 1'b1;
                MA     = ea_reg;
                WDATA  = PC;
                if (MEM_ACK) state_next = ST_LDP;
            end
            ST_LDP: begin
                PC_LD      = 1'b1;
                PC_IN      = (opcode == 3'd4) ? ea_reg + ADDR_W'(1) : ea_reg;
                state_next = ST_END;
            end
            ST_EXE: begin
                EXEC_GO    = 1'b1;
                state_next = ST_EXW;
            end
            ST_EXW: begin
                if (EXEC_DONE) state_next = SKIP ? ST_SKG : ST_END;
            end
            ST_SKG: begin
                state_next = ST_SKC;
            end
            ST_SKC: begin
                PC_CK      = 1'b1;
                state_next = ST_END;
            end
            ST_END: begin
                state_next = RUN ? ST_F0 : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign IR    = ir_reg;
    assign EA    = ea_reg;
    assign STATE = state_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: emulates PC, memory and execute unit around the DUT and
// checks every completed instruction against an instruction-level PDP-8 model.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, RUN;
    logic [11:0] PC, PCLAT, MD;
    logic        MEM_ACK, EXEC_DONE, SKIP;
    logic        PC_FETCH, PC_CK, PC_LD, MEM_RD, MEM_WR, EXEC_GO;
    logic [11:0] PC_IN, MA, WDATA, IR, EA;
    logic [3:0]  STATE;

    always #5 CLK = ~CLK;

    pc_sequencer #(.ADDR_W(12), .AUTOIDX_EN(1'b0)) dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .PC(PC), .PCLAT(PCLAT), .MD(MD),
        .MEM_ACK(MEM_ACK), .EXEC_DONE(EXEC_DONE), .SKIP(SKIP),
        .PC_FETCH(PC_FETCH), .PC_CK(PC_CK), .PC_LD(PC_LD), .PC_IN(PC_IN),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MA(MA), .WDATA(WDATA),
        .IR(IR), .EA(EA), .EXEC_GO(EXEC_GO), .STATE(STATE)
    );

    // Program counter neighbour.
    logic [11:0] pc_init;
    always @(posedge CLK) begin
        if (RESET) begin
            PC    <= pc_init;
            PCLAT <= 12'd0;
        end else begin
            if (PC_FETCH) begin
                PCLAT <= PC;
                PC    <= PC + 12'd1;
            end
            if (PC_CK) PC <= PC + 12'd1;
            if (PC_LD) PC <= PC_IN;
        end
    end

    logic [11:0] mem     [0:4095];
    logic [11:0] ref_mem [0:4095];
    logic [11:0] exp_pc;

    int total = 0;
    int bad   = 0;

    int cyc, n_end, n_fetch;
    int mem_lat, exec_lat, skip_force;
    bit spur, run_rand, drop_run_at_go;
    bit mem_busy, exec_busy, req_rd, last_skip;
    int mem_wait, exec_wait;
    logic [11:0] req_ma, req_wd;
    bit prev_fetch, prev_ck, prev_ld, prev_go;

    int rd_cnt, wr_cnt, ld_cnt, go_cnt, ck_cnt, rd0_len;
    int fetch_cyc, rd_start, done_cyc, ck_gap;
    logic [11:0] rd_ma0, rd_ma1, wr_ma, wr_data, ld_val;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0o expected=%0o (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic poke(input logic [11:0] addr, input logic [11:0] val);
        mem[addr]     = val;
        ref_mem[addr] = val;
    endtask

    // Instruction-level reference: one call per completed instruction.
    task automatic model_check();
        logic [11:0] a, ir, ea, def_addr, npc;
        logic [2:0]  op;
        logic        ind;
        int          go, ck, ld, wr;
        a        = exp_pc;
        ir       = ref_mem[a];
        op       = ir[11:9];
        ea       = ir[7] ? {a[11:7], ir[6:0]} : {5'd0, ir[6:0]};
        def_addr = ea;
        ind      = (op < 3'd6) && ir[8];
        if (ind) ea = ref_mem[def_addr];
        npc = a + 12'd1;
        go = 0; ck = 0; ld = 0; wr = 0;
        case (op)
            3'd5: begin ld = 1; npc = ea; end
            3'd4: begin wr = 1; ld = 1; ref_mem[ea] = a + 12'd1; npc = ea + 12'd1; end
            default: begin
                go = 1;
                if (last_skip) begin ck = 1; npc = npc + 12'd1; end
            end
        endcase
        check_eq("ir", 32'(IR), 32'(ir));
        check_eq("ea", 32'(EA), 32'(ea));
        check_eq("rd_count", 32'(rd_cnt), 32'(ind ? 2 : 1));
        check_eq("fetch_ma", 32'(rd_ma0), 32'(a));
        if (ind) check_eq("defer_ma", 32'(rd_ma1), 32'(def_addr));
        check_eq("wr_count", 32'(wr_cnt), 32'(wr));
        if (wr) begin
            check_eq("wr_ma", 32'(wr_ma), 32'(ea));
            check_eq("wr_data", 32'(wr_data), 32'(a + 12'd1));
            check_eq("mem_ret", 32'(mem[ea]), 32'(ref_mem[ea]));
        end
        check_eq("ld_count", 32'(ld_cnt), 32'(ld));
        if (ld) check_eq("pc_in", 32'(ld_val), 32'(npc));
        check_eq("go_count", 32'(go_cnt), 32'(go));
        check_eq("ck_count", 32'(ck_cnt), 32'(ck));
        if (ck) check_eq("ck_gap", 32'(ck_gap), 32'd2);
        check_eq("pc_after", 32'(PC), 32'(npc));
        $display("instr %0d at %04o ir=%04o ea=%04o next_pc=%04o", n_end, a, ir, ea, npc);
        exp_pc = npc;
    endtask

    // One clock of monitoring plus memory / execute-unit responses, at the falling edge.
    task automatic cycle();
        logic [5:0] viol;
        bit dropped, edone_prev;
        @(negedge CLK);
        cyc++;
        viol = {MEM_RD & MEM_WR, prev_fetch & PC_FETCH, prev_ck & PC_CK,
                prev_ld & PC_LD, prev_go & EXEC_GO, prev_fetch & PC_CK};
        check_eq("protocol", 32'(viol), 32'd0);
        prev_fetch = PC_FETCH; prev_ck = PC_CK; prev_ld = PC_LD; prev_go = EXEC_GO;

        if (PC_FETCH) begin
            n_fetch++; fetch_cyc = cyc;
            rd_cnt = 0; wr_cnt = 0; ld_cnt = 0; go_cnt = 0; ck_cnt = 0; rd0_len = 0;
            last_skip = 1'b0; done_cyc = -100; ck_gap = 0;
        end
        if (PC_LD) begin ld_cnt++; ld_val = PC_IN; end
        if (EXEC_GO) go_cnt++;
        if (PC_CK) begin ck_cnt++; ck_gap = cyc - done_cyc; end
        if (STATE == 4'd11) begin n_end++; model_check(); end

        dropped = MEM_ACK;
        MEM_ACK = 1'b0;
        MD      = 12'($urandom);
        if (dropped) mem_busy = 1'b0;
        if (MEM_RD || MEM_WR) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
                req_ma = MA; req_wd = WDATA; req_rd = MEM_RD;
                if (MEM_RD) begin
                    if (rd_cnt == 0) begin rd_ma0 = MA; rd_start = cyc; end
                    else rd_ma1 = MA;
                    rd_cnt++;
                end else begin
                    wr_cnt++; wr_ma = MA; wr_data = WDATA;
                end
            end else begin
                check_eq("req_hold", 32'({MA, WDATA, MEM_RD, MEM_WR}),
                         32'({req_ma, req_wd, req_rd, ~req_rd}));
            end
            if (MEM_RD && rd_cnt == 1) rd0_len++;
            if (mem_wait == 0 && !dropped) begin
                MEM_ACK = 1'b1;
                if (MEM_RD) MD = mem[MA];
                else        mem[MA] = WDATA;
            end else if (mem_wait > 0) begin
                mem_wait--;
            end
        end else if (spur && !dropped && $urandom_range(0, 7) == 0) begin
            MEM_ACK = 1'b1;
        end

        edone_prev = EXEC_DONE;
        EXEC_DONE  = 1'b0;
        SKIP       = 1'($urandom);
        if (EXEC_GO) begin
            exec_busy = 1'b1;
            exec_wait = (exec_lat < 0) ? int'($urandom_range(0, 3)) : exec_lat;
            if (drop_run_at_go) RUN = 1'b0;
        end else if (exec_busy && !edone_prev) begin
            if (exec_wait == 0) begin
                EXEC_DONE = 1'b1;
                SKIP      = (skip_force < 0) ? 1'($urandom) : 1'(skip_force);
                last_skip = SKIP;
                exec_busy = 1'b0;
                done_cyc  = cyc;
            end else begin
                exec_wait--;
            end
        end else if (spur && !exec_busy && !edone_prev && $urandom_range(0, 7) == 0) begin
            EXEC_DONE = 1'b1;
        end

        if (run_rand) RUN = ($urandom_range(0, 9) != 0);
    endtask

    task automatic run_instrs(input int n, input int budget, input string tag);
        int target;
        int k;
        target = n_end + n;
        k = 0;
        while (n_end < target && k < budget) begin
            cycle();
            k++;
        end
        check_eq(tag, 32'(n_end >= target), 32'd1);
    endtask

    task automatic do_reset(input logic [11:0] start_pc);
        RESET = 1'b1; RUN = 1'b0; MEM_ACK = 1'b0; EXEC_DONE = 1'b0; SKIP = 1'b0; MD = 12'd0;
        pc_init = start_pc;
        mem_busy = 1'b0; exec_busy = 1'b0; mem_wait = 0; exec_wait = 0;
        prev_fetch = 1'b0; prev_ck = 1'b0; prev_ld = 1'b0; prev_go = 1'b0;
        rd_cnt = 0; wr_cnt = 0; ld_cnt = 0; go_cnt = 0; ck_cnt = 0; rd0_len = 0;
        repeat (2) @(negedge CLK);
        check_eq("rst_state", 32'(STATE), 32'd0);
        check_eq("rst_strobes", 32'({PC_FETCH, PC_CK, PC_LD, MEM_RD, MEM_WR, EXEC_GO}), 32'd0);
        check_eq("rst_ir_ea", 32'({IR, EA}), 32'd0);
        check_eq("rst_ma_wdata", 32'({MA, WDATA}), 32'd0);
        check_eq("rst_pc_in", 32'(PC_IN), 32'd0);
        RESET  = 1'b0;
        exp_pc = start_pc;
    endtask

    initial begin
        int fetches;
        cyc = 0; n_end = 0; n_fetch = 0;
        spur = 1'b0; run_rand = 1'b0; drop_run_at_go = 1'b0;
        mem_lat = 3; exec_lat = 2; skip_force = 0;
        for (int i = 0; i < 4096; i++) poke(12'(i), 12'd0);
        poke(12'o0200, 12'o5377);
        poke(12'o0377, 12'o1410);
        poke(12'o0010, 12'o4000);
        poke(12'o0400, 12'o5420);
        poke(12'o0020, 12'o1200);
        poke(12'o1200, 12'o4300);
        poke(12'o1301, 12'o2050);
        poke(12'o1303, 12'o2051);
        poke(12'o1304, 12'o7000);

        do_reset(12'o0200);
        RUN = 1'b1;
        run_instrs(1, 100, "jmp_timeout");
        check_eq("fetch_to_rd", 32'(rd_start - fetch_cyc), 32'd1);
        check_eq("first_ma", 32'(rd_ma0), 32'o0200);
        check_eq("rd_held", 32'(rd0_len), 32'd4);
        check_eq("jmp_pc_in", 32'(ld_val), 32'o0377);
        check_eq("jmp_no_go", 32'(go_cnt), 32'd0);
        cycle();
        check_eq("jmp_refetch", 32'(PC_FETCH), 32'd1);

        mem_lat = 1;
        run_instrs(1, 100, "tad_i_timeout");
        check_eq("tad_i_defer_ma", 32'(rd_ma1), 32'o0010);
        check_eq("tad_i_ea", 32'(EA), 32'o4000);
        check_eq("tad_i_go", 32'(go_cnt), 32'd1);

        run_instrs(1, 100, "jmp_i_timeout");
        check_eq("jmp_i_pc_in", 32'(ld_val), 32'o1200);

        run_instrs(1, 100, "jms_timeout");
        check_eq("jms_wr_ma", 32'(wr_ma), 32'o1300);
        check_eq("jms_wr_data", 32'(wr_data), 32'o1201);
        check_eq("jms_pc_in", 32'(ld_val), 32'o1301);

        skip_force = 1;
        run_instrs(1, 100, "isz_skip_timeout");
        check_eq("isz_skip_ck", 32'(ck_cnt), 32'd1);
        check_eq("isz_skip_gap", 32'(ck_gap), 32'd2);
        check_eq("isz_skip_pc", 32'(PC), 32'o1303);

        skip_force = 0;
        run_instrs(1, 100, "isz_noskip_timeout");
        check_eq("isz_noskip_ck", 32'(ck_cnt), 32'd0);
        check_eq("isz_noskip_pc", 32'(PC), 32'o1304);

        drop_run_at_go = 1'b1;
        run_instrs(1, 100, "stop_timeout");
        drop_run_at_go = 1'b0;
        fetches = n_fetch;
        cycle();
        check_eq("stop_idle", 32'(STATE), 32'd0);
        repeat (10) cycle();
        check_eq("stop_no_fetch", 32'(n_fetch), 32'(fetches));

        // Reset in the middle of a stalled fetch read.
        do_reset(12'o3000);
        mem_lat = 20;
        RUN = 1'b1;
        for (int i = 0; i < 20 && rd0_len < 2; i++) cycle();
        check_eq("f1_reached", 32'(rd0_len >= 2), 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        check_eq("abort_mem_rd", 32'(MEM_RD), 32'd0);
        check_eq("abort_state", 32'(STATE), 32'd0);

        // Random program, random latencies, spurious handshakes and RUN chatter.
        for (int i = 0; i < 4096; i++) poke(12'(i), 12'($urandom));
        mem_lat = -1; exec_lat = -1; skip_force = -1;
        do_reset(12'($urandom));
        spur = 1'b1; run_rand = 1'b1;
        RUN = 1'b1;
        run_instrs(200, 30000, "random_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Major-state controller that sequences the program counter, memory reads/writes and the execute unit through the PDP-8 instruction cycle: fetch, optional defer, execute/skip.
- Drives the PC strobes (fetch, increment, load) as single-cycle pulses, spaced so the PC's edge detection on LD/FETCH and its CK-after-FETCH lockout never drop a request.
- Sits between the program counter, the memory interface and the ALU/execute unit.

Parameters:
- ADDR_W, 12, address/data width.
- AUTOIDX_EN, 0, reserved; must be 0. Autoindex (locations 0010-0017) is not performed by this block.

Ports:
- CLK  in  1  system clock
- RESET  in  1  reset
- RUN  in  1  level; 1 = keep starting instructions
- PC  in  12  current PC value
- PCLAT  in  12  PC latched at fetch (address of current instruction)
- MD  in  12  memory read data
- MEM_ACK  in  1  memory read/write complete (single cycle)
- EXEC_DONE  in  1  execute unit finished (single cycle)
- SKIP  in  1  skip condition, sampled with EXEC_DONE
- PC_FETCH  out  1  pulse: PCLAT<=PC, PC+1
- PC_CK  out  1  pulse: PC+1 (skip)
- PC_LD  out  1  pulse: PC<=PC_IN
- PC_IN  out  12  load value for PC
- MEM_RD  out  1  read request, held until MEM_ACK
- MEM_WR  out  1  write request, held until MEM_ACK
- MA  out  12  memory address
- WDATA  out  12  memory write data
- IR  out  12  instruction register
- EA  out  12  effective address
- EXEC_GO  out  1  pulse: start execute unit
- STATE  out  4  current state encoding

Behaviour:
- Reset is RESET: synchronous, active-high. Clock is CLK.
- Reset takes priority over everything. It aborts any state, including a pending memory request. Next cycle: STATE=IDLE and all outputs 0.
- States and encodings:
  - IDLE (0): outputs idle. RUN=1 -> F0.
  - F0 (1): PC_FETCH=1 for exactly one cycle -> F1.
  - F1 (2): MEM_RD=1, MA=PCLAT. On MEM_ACK: IR<=MD -> DEC.
  - DEC (3):
    - EA <= IR[7] ? {PCLAT[11:7],IR[6:0]} : {5'b0,IR[6:0]}.
    - Opcode IR[11:9]<6 with IR[8]=1 -> DEF.
    - Otherwise: opcode 5 -> LDP, opcode 4 -> JWR, else -> EXE.
    - Opcodes 6 and 7 ignore IR[8].
  - DEF (4): MEM_RD=1, MA=EA. On MEM_ACK: EA<=MD, then dispatch as in DEC.
  - JWR (5): MEM_WR=1, MA=EA, WDATA=PC (return address). On MEM_ACK -> LDP.
  - LDP (6): PC_LD=1 for one cycle. PC_IN=EA for JMP, EA+1 (mod 4096) for JMS -> END.
  - EXE (7): EXEC_GO=1 for one cycle -> EXW.
  - EXW (8): wait for EXEC_DONE. SKIP=1 at that cycle -> SKG, else -> END.
  - SKG (9): one idle gap cycle -> SKC.
  - SKC (10): PC_CK=1 for one cycle -> END.
  - END (11): RUN=1 -> F0, else -> IDLE.
- PC_IN, MA and WDATA hold their value while the associated strobe or request is asserted.
- Every strobe is a one-cycle pulse with at least one low cycle before its next assertion.
- PC_CK is never asserted in the cycle after PC_FETCH.
- RUN is sampled only in IDLE and END. Dropping RUN mid-instruction completes the instruction, then stops.
- MEM_ACK outside F1/DEF/JWR is ignored. EXEC_DONE outside EXW is ignored.
- Wait states have no timeout; the block stalls indefinitely.
- EA arithmetic is 12-bit with wrap (o7777+1 = o0000).
- MEM_RD and MEM_WR are never asserted together.

Test Plan:
- Reset, then RUN=1, PC=o0200:
  - PC_FETCH high one cycle.
  - Next cycle MEM_RD=1 with MA=PCLAT=o0200.
  - Held through 3 wait cycles until MEM_ACK.
- JMP direct, current page: IR=o5377, PCLAT=o0200 -> EA=o0377; PC_LD one cycle with PC_IN=o0377; no EXEC_GO; back to F0.
- Indirect TAD: IR=o1410 -> DEF reads MA=o0010; MD=o4000 -> EA=o4000; EXEC_GO one cycle.
- JMS: IR=o4300, PCLAT=o1200, PC=o1201:
  - MEM_WR with MA=o1300, WDATA=o1201.
  - Then PC_LD with PC_IN=o1301.
- ISZ with skip: EXEC_DONE=1 and SKIP=1 -> one gap cycle, then PC_CK exactly one cycle. Same with SKIP=0 -> no PC_CK.
- RESET asserted during the F1 wait: MEM_RD=0 and STATE=0 next cycle. RUN=0 during EXW: after EXEC_DONE, END then IDLE, with no further PC_FETCH.
